pc16_counter: RTL and testbench
===============================

Name: pc16_counter

Overview:
- 16-bit program counter that registers the word produced by the upstream Mux16 selection network and holds it as the current instruction address.
- Implements Hack-style priority: reset, then load, then inc, then hold.
- Adds three things on top of that: a boot-hold FSM after reset, a halt/resume control, and a wrap-around flag.
- Sits between the jump-target mux (A-register vs. computed target) and instruction ROM addressing.

Parameters:
- WIDTH, 16, datapath width; the bench uses only 16.
- BOOT_CYCLES, 4, number of cycles out is held at BOOT_ADDR after reset deasserts; legal range 1..15.
- BOOT_ADDR, 16'h0000, address loaded on reset and held during boot.

Ports:
- clk  input  1  single clock; all state updates on posedge clk.
- reset  input  1  synchronous, active-high reset.
- in  input  WIDTH  load target from the upstream Mux16 output.
- load  input  1  when set, out <= in (in RUN only).
- inc  input  1  when set and load clear, out <= out + 1 (in RUN only).
- halt_req  input  1  request to freeze the counter.
- resume  input  1  request to leave HALT.
- out  output  WIDTH  registered current address.
- next_out  output  WIDTH  combinational value out will take at the next edge.
- wrapped  output  1  registered one-cycle pulse on an increment from 16'hFFFF to 16'h0000.
- halted  output  1  registered; high while in HALT.
- booting  output  1  registered; high while in BOOT.

Behaviour:
- Reset (sampled at posedge, synchronous, active-high):
  - out = BOOT_ADDR, wrapped = 0, halted = 0, booting = 1.
  - State = BOOT, boot counter = BOOT_CYCLES-1.
  - Reset wins over every other input in every state, including mid-boot and mid-halt.
- States: BOOT, RUN, HALT (2-bit encoding).
- BOOT:
  - out is held at BOOT_ADDR; load, inc and halt_req are ignored.
  - The counter decrements each cycle. When it is 0 at an edge, state moves to RUN and booting goes to 0 at that edge.
  - With BOOT_CYCLES = 4, booting is high for exactly 4 cycles after reset deasserts.
- RUN, evaluated in this priority order:
  - halt_req: state goes to HALT; out holds; halted goes to 1 at the same edge. Any load or inc in that cycle is dropped.
  - Else load: out <= in (inc ignored).
  - Else inc: out <= out + 1, modulo 2^WIDTH.
  - Else: out holds.
- HALT:
  - out holds; load, inc and halt_req are ignored.
  - resume moves state to RUN; halted goes to 0 at that edge and out is unchanged.
  - The first load or inc takes effect in the cycle after leaving HALT.
  - resume is ignored in BOOT and RUN.
- wrapped:
  - Goes to 1 for exactly one cycle, at the edge where an increment moves out from 16'hFFFF to 16'h0000.
  - A load of 16'h0000 does not set it.
  - It is cleared at every other edge.
- next_out:
  - Pure combinational mirror of the priority logic, including state gating.
  - Equals out whenever state ≠ RUN, or when halt_req is set in RUN.
  - Equals BOOT_ADDR when reset is high.
  - No latency: out at edge N+1 always equals next_out sampled just before edge N.
- Latency: load or inc to out is 1 cycle. No combinational path from in to out; the only one is from in to next_out.
- Simultaneous halt_req and resume in RUN: halt wins. Simultaneous halt_req and resume in HALT: resume wins, and state goes to RUN.

Decomposition:
- Package pc16_pkg holds:
  - the state enum (ST_BOOT = 2'd0, ST_RUN = 2'd1, ST_HALT = 2'd2);
  - the constant PC_WIDTH = 16;
  - the constant PC_MAX = 16'hFFFF.
- One sub-module, pc16_next_sel: purely combinational.
  - Inputs: out, in, load, inc, state_is_run, halt_req, reset.
  - Outputs: next_out and an inc_wrap flag.
  - Built as a chain of three 16-bit two-way selects: inc/hold, then load, then reset.
- The top level holds the FSM, the boot counter and the output registers.

Test Plan:
- Reset then boot: hold reset 2 cycles, drive inc = 1 throughout.
  - out stays 16'h0000 and booting = 1 for 4 cycles.
  - On the 5th cycle booting = 0 and out goes to 1 on the following edge.
- Priority in RUN: out = 16'h0010, load = 1, inc = 1, in = 16'h1234 → out = 16'h1234 after 1 edge.
  - Then load = 0, inc = 1 → 16'h1235.
  - Then both low → holds at 16'h1235.
- Wrap: load 16'hFFFE, then inc for 2 cycles.
  - Sequence is 16'hFFFF, 16'h0000.
  - wrapped = 1 only in the cycle out = 16'h0000; it is 0 again the next cycle.
  - A separate load of 16'h0000 leaves wrapped at 0.
- Halt/resume: out = 16'h0100, halt_req = 1 with inc = 1.
  - out stays 16'h0100 and halted = 1.
  - 3 cycles of inc/load while halted: no change.
  - resume = 1 → halted = 0 with out still 16'h0100; the next inc gives 16'h0101.
- Reset mid-operation: assert reset while halted with out = 16'hABCD.
  - Next edge: out = 16'h0000, halted = 0, booting = 1, and the full 4-cycle boot repeats.
- next_out check: every cycle, randomised load/inc/in/halt_req/resume → out(t+1) == next_out(t) sampled before edge t.

Source files
------------

// File: rtl/pc16_pkg.sv
// Shared types and constants for the pc16 program counter slice.
package pc16_pkg;

  localparam int unsigned PC_WIDTH = 16;
  localparam logic [PC_WIDTH-1:0] PC_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } pc_state_e;

endpackage

// File: rtl/pc16_next_sel.sv
// Combinational next-address select: inc/hold, then load, then reset.
module pc16_next_sel
  import pc16_pkg::*;
#(
  parameter int unsigned      WIDTH     = PC_WIDTH,
  parameter logic [WIDTH-1:0] BOOT_ADDR = '0
) (
  input  logic [WIDTH-1:0] out,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  input  logic             inc,
  input  logic             state_is_run,
  input  logic             halt_req,
  input  logic             reset,
  output logic [WIDTH-1:0] next_out,
  output logic             inc_wrap
);

  logic             advance;
  logic [WIDTH-1:0] inc_sel;
  logic [WIDTH-1:0] load_sel;

  always_comb begin
    // A halt request in RUN drops any load/inc of the same cycle.
    advance  = state_is_run & ~halt_req;
    inc_sel  = (advance & inc) ? out + WIDTH'(1) : out;
    load_sel = (advance & load) ? in : inc_sel;
    next_out = reset ? BOOT_ADDR : load_sel;
    inc_wrap = advance & inc & ~load & ~reset & (out == '1);
  end

endmodule

// File: rtl/pc16_counter.sv
// 16-bit Hack-style program counter with boot hold, halt/resume and wrap flag.
module pc16_counter
  import pc16_pkg::*;
#(
  parameter int unsigned      WIDTH       = PC_WIDTH,
  parameter int unsigned      BOOT_CYCLES = 4,
  parameter logic [WIDTH-1:0] BOOT_ADDR   = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  input  logic             inc,
  input  logic             halt_req,
  input  logic             resume,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] next_out,
  output logic             wrapped,
  output logic             halted,
  output logic             booting
);

  localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);

  pc_state_e        state_q, state_d;
  logic [3:0]       boot_cnt_q, boot_cnt_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             wrapped_q, wrapped_d;
  logic             halted_q, halted_d;
  logic             booting_q, booting_d;
  logic             inc_wrap;

  pc16_next_sel #(
    .WIDTH     (WIDTH),
    .BOOT_ADDR (BOOT_ADDR)
  ) u_next_sel (
    .out          (out_q),
    .in           (in),
    .load         (load),
    .inc          (inc),
    .state_is_run (state_q == ST_RUN),
    .halt_req     (halt_req),
    .reset        (reset),
    .next_out     (out_d),
    .inc_wrap     (inc_wrap)
  );

  always_comb begin
    state_d    = state_q;
    boot_cnt_d = boot_cnt_q;
    case (state_q)
      ST_BOOT: begin
        if (boot_cnt_q == '0) state_d = ST_RUN;
        else                  boot_cnt_d = boot_cnt_q - 4'd1;
      end
      ST_RUN:  if (halt_req) state_d = ST_HALT;
      ST_HALT: if (resume)   state_d = ST_RUN;
      default: state_d = ST_BOOT;
    endcase
    // Status flags are registered copies of the state being entered.
    halted_d  = (state_d == ST_HALT);
    booting_d = (state_d == ST_BOOT);
    wrapped_d = inc_wrap;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_BOOT;
      boot_cnt_q <= BOOT_LAST;
      out_q      <= BOOT_ADDR;
      wrapped_q  <= 1'b0;
      halted_q   <= 1'b0;
      booting_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      boot_cnt_q <= boot_cnt_d;
      out_q      <= out_d;
      wrapped_q  <= wrapped_d;
      halted_q   <= halted_d;
      booting_q  <= booting_d;
    end
  end

  assign out      = out_q;
  assign next_out = out_d;
  assign wrapped  = wrapped_q;
  assign halted   = halted_q;
  assign booting  = booting_q;

endmodule

// File: tb/tb_pc16_counter.sv
// Randomised and directed bench for pc16_counter against a behavioural model.
module tb_pc16_counter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] in_w = '0;
  logic        load = 1'b0;
  logic        inc = 1'b0;
  logic        halt_req = 1'b0;
  logic        resume = 1'b0;
  logic [15:0] out;
  logic [15:0] next_out;
  logic        wrapped;
  logic        halted;
  logic        booting;

  int checks = 0;
  int errors = 0;

  // Model state: remaining boot cycles, halt flag, address, last wrap.
  int m_out;
  int m_boot_left;
  bit m_halted;
  bit m_wrapped;
  bit m_valid = 1'b0;

  pc16_counter #(
    .WIDTH       (16),
    .BOOT_CYCLES (4),
    .BOOT_ADDR   (16'h0000)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in       (in_w),
    .load     (load),
    .inc      (inc),
    .halt_req (halt_req),
    .resume   (resume),
    .out      (out),
    .next_out (next_out),
    .wrapped  (wrapped),
    .halted   (halted),
    .booting  (booting)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs after negedge, check next_out, then outputs after posedge.
  task automatic cycle(input bit r, input bit l, input bit i, input bit h, input bit rs,
                       input logic [15:0] d);
    int n_out, n_boot;
    bit n_halt, n_wrap;
    @(negedge clk);
    reset = r; load = l; inc = i; halt_req = h; resume = rs; in_w = d;
    n_out = m_out; n_boot = m_boot_left; n_halt = m_halted; n_wrap = 1'b0;
    if (r) begin
      n_out = 0; n_boot = 4; n_halt = 1'b0;
    end else if (m_boot_left > 0) begin
      n_boot = m_boot_left - 1;
    end else if (m_halted) begin
      if (rs) n_halt = 1'b0;
    end else if (h) begin
      n_halt = 1'b1;
    end else if (l) begin
      n_out = int'(d);
    end else if (i) begin
      n_out = (m_out + 1) % 65536;
      n_wrap = (m_out == 65535);
    end
    #1;
    if (m_valid || r) check("next_out", {16'h0, next_out}, n_out);
    @(posedge clk);
    #1;
    m_out = n_out; m_boot_left = n_boot; m_halted = n_halt; m_wrapped = n_wrap;
    m_valid = m_valid | r;
    if (m_valid) begin
      check("out", {16'h0, out}, m_out);
      check("wrapped", {31'h0, wrapped}, {31'h0, m_wrapped});
      check("halted", {31'h0, halted}, {31'h0, m_halted});
      check("booting", {31'h0, booting}, (m_boot_left > 0) ? 1 : 0);
    end
  endtask

  initial begin
    // Reset then boot with inc held high.
    cycle(1, 0, 1, 0, 0, 16'h0);
    cycle(1, 0, 1, 0, 0, 16'h0);
    check("reset_out", {16'h0, out}, 32'h0);
    check("reset_booting", {31'h0, booting}, 32'h1);
    for (int unsigned k = 0; k < 4; k++) begin
      cycle(0, 0, 1, 0, 0, 16'h0);
      check("boot_out", {16'h0, out}, 32'h0);
      check("boot_flag", {31'h0, booting}, (k < 3) ? 32'h1 : 32'h0);
    end
    cycle(0, 0, 1, 0, 0, 16'h0);
    check("first_inc", {16'h0, out}, 32'h1);

    // Priority in RUN.
    cycle(0, 1, 0, 0, 0, 16'h0010);
    cycle(0, 1, 1, 0, 0, 16'h1234);
    check("load_over_inc", {16'h0, out}, 32'h1234);
    cycle(0, 0, 1, 0, 0, 16'h5555);
    check("inc", {16'h0, out}, 32'h1235);
    cycle(0, 0, 0, 0, 0, 16'h5555);
    check("hold", {16'h0, out}, 32'h1235);

    // Wrap.
    cycle(0, 1, 0, 0, 0, 16'hFFFE);
    cycle(0, 0, 1, 0, 0, 16'h0);
    check("pre_wrap", {16'h0, out}, 32'hFFFF);
    check("pre_wrap_flag", {31'h0, wrapped}, 32'h0);
    cycle(0, 0, 1, 0, 0, 16'h0);
    check("wrap_out", {16'h0, out}, 32'h0);
    check("wrap_flag", {31'h0, wrapped}, 32'h1);
    cycle(0, 0, 0, 0, 0, 16'h0);
    check("wrap_clear", {31'h0, wrapped}, 32'h0);
    cycle(0, 1, 0, 0, 0, 16'hFFFF);
    cycle(0, 1, 0, 0, 0, 16'h0000);
    check("load0_nowrap", {31'h0, wrapped}, 32'h0);

    // Halt / resume.
    cycle(0, 1, 0, 0, 0, 16'h0100);
    cycle(0, 0, 1, 1, 0, 16'h0);
    check("halt_out", {16'h0, out}, 32'h0100);
    check("halt_flag", {31'h0, halted}, 32'h1);
    for (int unsigned k = 0; k < 3; k++) cycle(0, k[0], 1, 0, 0, 16'h7777);
    check("halted_hold", {16'h0, out}, 32'h0100);
    cycle(0, 0, 0, 1, 1, 16'h0);
    check("resume_flag", {31'h0, halted}, 32'h0);
    check("resume_out", {16'h0, out}, 32'h0100);
    cycle(0, 0, 1, 0, 0, 16'h0);
    check("post_resume_inc", {16'h0, out}, 32'h0101);

    // Reset while halted.
    cycle(0, 1, 0, 0, 0, 16'hABCD);
    cycle(0, 0, 0, 1, 0, 16'h0);
    check("halt_abcd", {16'h0, out}, 32'hABCD);
    cycle(1, 1, 1, 1, 1, 16'h1111);
    check("mid_reset_out", {16'h0, out}, 32'h0);
    check("mid_reset_halted", {31'h0, halted}, 32'h0);
    check("mid_reset_booting", {31'h0, booting}, 32'h1);
    for (int unsigned k = 0; k < 5; k++) cycle(0, 0, 1, 1, 0, 16'h0);

    // Randomised traffic against the model.
    for (int unsigned k = 0; k < 600; k++) begin
      logic [15:0] d;
      d = ($urandom_range(0, 7) == 0) ? 16'hFFFF - 16'($urandom_range(0, 2))
                                      : 16'($urandom);
      cycle($urandom_range(0, 59) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0,
            $urandom_range(0, 3) == 0, d);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
